// File: rtl/ls7212_pkg.sv
// Shared types and defaults for the LS7212 response monitor.
package ls7212_pkg;

    localparam int unsigned DefaultCntW    = 16;
    localparam int unsigned DefaultTimeout = 32'h0000_FFFF;

    typedef enum logic [1:0] {
        KindAssert  = 2'b00,
        KindRelease = 2'b01,
        KindTimeout = 2'b10
    } rec_kind_t;

    // Record layout at the default counter width; the top packs the same field order.
    typedef struct packed {
        rec_kind_t              kind;
        logic [DefaultCntW-1:0] delta;
        logic [DefaultCntW-1:0] width;
        logic                   sat;
    } rec_t;

endpackage

// File: rtl/ls7212_rec_fifo.sv
// Single-clock record FIFO with valid/ready pop and sticky drop-on-full flag.
module ls7212_rec_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DepthVal = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop, push_ok;

    // Pointer, count and storage next-state; a pop frees a slot for a same-cycle push.
    always_comb begin
        pop_valid = (count_q != '0);
        empty     = ~pop_valid;
        full      = (count_q == DepthVal);
        pop_data  = pop_valid ? mem_q[rd_ptr_q] : '0;
        pop       = pop_valid & pop_ready;
        push_ok   = push & (~full | pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | (push & ~push_ok);
        overflow   = overflow_q;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the empty gate masks stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ls7212_response_monitor.sv
// Measures LS7212 delay_out_n timing against its trigger and queues timestamped records.
module ls7212_response_monitor
    import ls7212_pkg::*;
#(
    parameter int unsigned CNT_W   = DefaultCntW,
    parameter int unsigned TIMEOUT = DefaultTimeout,
    parameter int unsigned DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             delay_out_n,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [1:0]       rec_kind,
    output logic [CNT_W-1:0] rec_delta,
    output logic [CNT_W-1:0] rec_width,
    output logic             rec_sat,
    output logic             overflow
);
    localparam int unsigned      RecW       = 2 + 2 * CNT_W + 1;
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    logic             trig_s1_q, trig_s1_d, trig_s2_q, trig_s2_d;
    logic             dout_q, dout_d;
    logic             armed_q, armed_d, edge_seen_q, edge_seen_d;
    logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d, low_cnt_q, low_cnt_d;
    logic             trig_edge, fall, rise, out_edge, timeout_hit;
    logic             push, push_sat;
    rec_kind_t        push_kind;
    logic [CNT_W-1:0] push_delta, push_width;
    logic [RecW-1:0]  push_data, head_data;
    logic             fifo_full, fifo_empty;
    logic             unused_fifo_flags;

    // Edge detection, record formation and counter next-state.
    always_comb begin
        trig_s1_d   = trigger;
        trig_s2_d   = trig_s1_q;
        dout_d      = delay_out_n;
        trig_edge   = trig_s1_q ^ trig_s2_q;
        fall        = dout_q & ~delay_out_n;
        rise        = ~dout_q & delay_out_n;
        out_edge    = fall | rise;
        timeout_hit = armed_q & ~edge_seen_q & (trig_cnt_q == TimeoutVal);
        push        = out_edge | timeout_hit;

        // Output edges outrank a coincident timeout; counters are captured pre-load.
        push_kind  = KindAssert;
        push_delta = armed_q ? trig_cnt_q : CntMax;
        push_width = '0;
        if (rise) begin
            push_kind  = KindRelease;
            push_width = low_cnt_q;
        end else if (!fall && timeout_hit) begin
            push_kind  = KindTimeout;
            push_delta = TimeoutVal;
        end
        push_sat  = (push_delta == CntMax) | (push_width == CntMax) | ~armed_q;
        push_data = {push_kind, push_delta, push_width, push_sat};

        armed_d     = armed_q;
        edge_seen_d = edge_seen_q;
        if (out_edge) begin
            edge_seen_d = 1'b1;
        end else if (timeout_hit) begin
            armed_d = 1'b0;
        end
        // A new trigger edge re-arms and restarts measurement, overriding the above.
        if (trig_edge) begin
            trig_cnt_d  = CNT_W'(1);
            armed_d     = 1'b1;
            edge_seen_d = 1'b0;
        end else if (trig_cnt_q != CntMax) begin
            trig_cnt_d = trig_cnt_q + CNT_W'(1);
        end else begin
            trig_cnt_d = trig_cnt_q;
        end

        if (fall) begin
            low_cnt_d = CNT_W'(1);
        end else if (!delay_out_n && low_cnt_q != CntMax) begin
            low_cnt_d = low_cnt_q + CNT_W'(1);
        end else begin
            low_cnt_d = low_cnt_q;
        end
    end

    // Synchronizer, output sampler and measurement counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            dout_q      <= 1'b1;
            armed_q     <= 1'b0;
            edge_seen_q <= 1'b0;
            trig_cnt_q  <= CntMax;
            low_cnt_q   <= '0;
        end else begin
            trig_s1_q   <= trig_s1_d;
            trig_s2_q   <= trig_s2_d;
            dout_q      <= dout_d;
            armed_q     <= armed_d;
            edge_seen_q <= edge_seen_d;
            trig_cnt_q  <= trig_cnt_d;
            low_cnt_q   <= low_cnt_d;
        end
    end

    ls7212_rec_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(RecW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop_valid(rec_valid),
        .pop_ready(rec_ready),
        .pop_data (head_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign unused_fifo_flags = fifo_full ^ fifo_empty;

    assign rec_kind  = head_data[RecW-1 -: 2];
    assign rec_delta = head_data[RecW-3 -: CNT_W];
    assign rec_width = head_data[CNT_W -: CNT_W];
    assign rec_sat   = head_data[0];

endmodule

// File: tb/tb_ls7212_response_monitor.sv
// Directed bench: drives trigger/delay_out_n by hand and checks the emitted records.
module tb_ls7212_response_monitor;
    import ls7212_pkg::*;

    logic        clk = 1'b0;
    logic        reset, trigger, delay_out_n, rec_ready;
    logic        rec_valid, rec_sat, overflow;
    logic [1:0]  rec_kind;
    logic [15:0] rec_delta, rec_width;

    int   checks = 0;
    int   errors = 0;
    rec_t seen_q[$];

    always #5 clk = ~clk;

    ls7212_response_monitor #(
        .CNT_W  (16),
        .TIMEOUT(100),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trigger    (trigger),
        .delay_out_n(delay_out_n),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_kind   (rec_kind),
        .rec_delta  (rec_delta),
        .rec_width  (rec_width),
        .rec_sat    (rec_sat),
        .overflow   (overflow)
    );

    // Capture every accepted record away from the active edge.
    always @(negedge clk) begin
        if (!reset && rec_valid && rec_ready) begin
            seen_q.push_back({rec_kind, rec_delta, rec_width, rec_sat});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_rec(input string tag, input logic [1:0] kind, input logic [15:0] delta,
                              input logic [15:0] width, input logic sat);
        rec_t r;
        if (seen_q.size() == 0) begin
            check_eq({tag, "_present"}, seen_q.size(), 1);
            return;
        end
        r = seen_q.pop_front();
        check_eq({tag, "_kind"}, 32'(r.kind), 32'(kind));
        check_eq({tag, "_delta"}, 32'(r.delta), 32'(delta));
        check_eq({tag, "_width"}, 32'(r.width), 32'(width));
        check_eq({tag, "_sat"}, 32'(r.sat), 32'(sat));
    endtask

    initial begin
        reset       = 1'b1;
        trigger     = 1'b0;
        delay_out_n = 1'b1;
        rec_ready   = 1'b1;
        cycles(3);
        check_eq("rst_valid", rec_valid, 0);
        check_eq("rst_kind", rec_kind, 0);
        check_eq("rst_delta", rec_delta, 0);
        check_eq("rst_width", rec_width, 0);
        check_eq("rst_sat", rec_sat, 0);
        check_eq("rst_overflow", overflow, 0);
        reset = 1'b0;
        cycles(5);
        check_eq("idle_count", seen_q.size(), 0);

        // One-shot: fall 3 cycles after trigger detection, 6 cycles low.
        trigger = 1'b1;
        cycles(4);
        delay_out_n = 1'b0;
        cycles(6);
        delay_out_n = 1'b1;
        cycles(5);
        check_eq("os_count", seen_q.size(), 2);
        expect_rec("os_assert", KindAssert, 16'd3, 16'd0, 1'b0);
        expect_rec("os_release", KindRelease, 16'd9, 16'd6, 1'b0);

        // Lone trigger edge with no response times out once.
        trigger = 1'b0;
        cycles(150);
        check_eq("to1_count", seen_q.size(), 1);
        expect_rec("to1", KindTimeout, 16'd100, 16'd0, 1'b0);

        // Delayed dual: release measured from the trigger's falling edge.
        trigger = 1'b1;
        cycles(12);
        delay_out_n = 1'b0;
        cycles(28);
        trigger = 1'b0;
        cycles(12);
        delay_out_n = 1'b1;
        cycles(5);
        check_eq("dd_count", seen_q.size(), 2);
        expect_rec("dd_assert", KindAssert, 16'd11, 16'd0, 1'b0);
        expect_rec("dd_release", KindRelease, 16'd11, 16'd40, 1'b0);

        // Long quiet period after a toggle: exactly one timeout, counter saturates silently.
        trigger = 1'b1;
        cycles(70000);
        check_eq("to2_count", seen_q.size(), 1);
        expect_rec("to2", KindTimeout, 16'd100, 16'd0, 1'b0);

        // FIFO fill: six output edges with the consumer stalled.
        rec_ready = 1'b0;
        trigger   = 1'b0;
        cycles(4);
        for (int i = 0; i < 6; i++) begin
            delay_out_n = ~delay_out_n;
            cycles(2);
        end
        cycles(1);
        check_eq("ff_held_count", seen_q.size(), 0);
        check_eq("ff_overflow", overflow, 1);
        check_eq("ff_valid", rec_valid, 1);
        check_eq("ff_head_kind", rec_kind, 0);
        check_eq("ff_head_delta", rec_delta, 3);
        cycles(3);
        check_eq("ff_stable_delta", rec_delta, 3);
        rec_ready = 1'b1;
        cycles(6);
        check_eq("ff_drain_count", seen_q.size(), 4);
        expect_rec("ff_r0", KindAssert, 16'd3, 16'd0, 1'b0);
        expect_rec("ff_r1", KindRelease, 16'd5, 16'd2, 1'b0);
        expect_rec("ff_r2", KindAssert, 16'd7, 16'd0, 1'b0);
        expect_rec("ff_r3", KindRelease, 16'd9, 16'd2, 1'b0);
        check_eq("ff_overflow_sticky", overflow, 1);
        check_eq("ff_empty", rec_valid, 0);

        // Trigger edge and fall detected in the same cycle.
        trigger = 1'b1;
        cycles(20);
        trigger = 1'b0;
        tick();
        delay_out_n = 1'b0;
        cycles(5);
        delay_out_n = 1'b1;
        cycles(5);
        check_eq("sim_count", seen_q.size(), 2);
        expect_rec("sim_assert", KindAssert, 16'd20, 16'd0, 1'b0);
        expect_rec("sim_release", KindRelease, 16'd5, 16'd5, 1'b0);

        // Reset while the output is low.
        delay_out_n = 1'b0;
        cycles(3);
        reset = 1'b1;
        tick();
        check_eq("mr_valid", rec_valid, 0);
        check_eq("mr_overflow", overflow, 0);
        tick();
        reset = 1'b0;
        seen_q.delete();
        check_eq("mr_valid_after", rec_valid, 0);
        cycles(3);
        delay_out_n = 1'b1;
        cycles(5);
        check_eq("mr_count", seen_q.size(), 2);
        expect_rec("mr_assert", KindAssert, 16'hFFFF, 16'd0, 1'b1);
        expect_rec("mr_release", KindRelease, 16'hFFFF, 16'd3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
